// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NUM_PORTS split req/addr_ok/data_ok masters onto one RAM port, routing in-order responses via an owner-tag FIFO.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default is round-robin.
module mem_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [NUM_PORTS-1:0]        m_req,
    input  logic [NUM_PORTS-1:0]        m_write,
    input  logic [NUM_PORTS*XLEN/8-1:0] m_wstrb,
    input  logic [NUM_PORTS*XLEN-1:0]   m_addr,
    input  logic [NUM_PORTS*XLEN-1:0]   m_wdata,
    output logic [NUM_PORTS-1:0]        m_addr_ok,
    output logic [NUM_PORTS-1:0]        m_data_ok,
    output logic [XLEN-1:0]             m_rdata,
    output logic                        s_req,
    output logic                        s_write,
    output logic [XLEN/8-1:0]           s_wstrb,
    output logic [XLEN-1:0]             s_addr,
    output logic [XLEN-1:0]             s_wdata,
    input  logic                        s_addr_ok,
    input  logic                        s_data_ok,
    input  logic [XLEN-1:0]             s_rdata,
    output logic                        resp_err
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int SW = XLEN / 8;

    logic [GW-1:0] arb_grant, grant, lock_id;
    logic          locked;
    logic [GW-1:0] tags [MAX_OUTSTANDING];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, accept, pop;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        arb_grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (m_req[i]) arb_grant = GW'(i);
    end
`else
    logic [GW-1:0]            rr_ptr;
    logic [2*NUM_PORTS-1:0]   rot;
    // Rotate requests so bit 0 is the rr pointer; the lowest set bit is the winner.
    always_comb begin
        rot = {m_req, m_req} >> rr_ptr;
        arb_grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (rot[i]) arb_grant = GW'((int'(rr_ptr) + i) % NUM_PORTS);
    end

    always_ff @(posedge clk or posedge rst_b)
        if (rst_b)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
`endif

    assign grant  = locked ? lock_id : arb_grant;
    assign full   = count == (AW+1)'(MAX_OUTSTANDING);
    assign empty  = count == '0;
    // Reset gates the handshake outputs so they drop the moment reset asserts.
    assign s_req  = !rst_b && |m_req && !full;
    assign accept = s_req && s_addr_ok;
    assign pop    = !rst_b && s_data_ok && !empty;

    always_comb begin
        m_addr_ok = accept ? NUM_PORTS'(1) << grant : '0;
        m_data_ok = pop ? NUM_PORTS'(1) << tags[rd_ptr] : '0;
        m_rdata   = rst_b ? '0 : s_rdata;
        s_write   = s_req && m_write[grant];
        s_wstrb   = s_req ? m_wstrb[grant*SW +: SW] : '0;
        s_addr    = s_req ? m_addr[grant*XLEN +: XLEN] : '0;
        s_wdata   = s_req ? m_wdata[grant*XLEN +: XLEN] : '0;
    end

    always_ff @(posedge clk)
        if (accept) tags[wr_ptr] <= grant;

    always_ff @(posedge clk or posedge rst_b)
        if (rst_b) begin
            locked   <= 1'b0;
            lock_id  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (accept)
                locked <= 1'b0;
            else if (s_req) begin
                locked  <= 1'b1;
                lock_id <= grant;
            end
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (s_data_ok && empty) resp_err <= 1'b1;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, lock, full, error and async reset behaviour.
module tb_mem_port_arbiter;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FX = 1'b1;
`else
    localparam bit FX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic [1:0]  m_req, m_write, m_addr_ok, m_data_ok;
    logic [7:0]  m_wstrb;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_req, s_write, s_addr_ok, s_data_ok, resp_err;
    int          errors = 0;
    int          checks = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_req = 0; m_write = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
        cyc(); m_req = 2'b01; s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h1234; #1;
        chk("rst_s_req", 32'(s_req), 0);
        chk("rst_addr_ok", 32'(m_addr_ok), 0);
        chk("rst_data_ok", 32'(m_data_ok), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_m_rdata", m_rdata, 0);
        cyc(); m_req = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = 0; rst_b = 0;
        cyc(); chk("post_rst_err", 32'(resp_err), 0);
        // single port 1 read
        cyc(); m_req = 2'b10; m_addr[63:32] = 32'h100; s_addr_ok = 1; #1;
        chk("p1_s_req", 32'(s_req), 1);
        chk("p1_s_addr", s_addr, 32'h100);
        chk("p1_addr_ok", 32'(m_addr_ok), 32'b10);
        chk("p1_s_write", 32'(s_write), 0);
        cyc(); m_req = 0; s_addr_ok = 0; #1;
        chk("p1_wait_data_ok", 32'(m_data_ok), 0);
        cyc(); s_data_ok = 1; s_rdata = 32'hDEADBEEF; #1;
        chk("p1_data_ok", 32'(m_data_ok), 32'b10);
        chk("p1_rdata", m_rdata, 32'hDEADBEEF);
        cyc(); s_data_ok = 0; s_rdata = 0;
        // contention until full, then pops interleaved with pushes
        m_addr = {32'h300, 32'h200}; m_req = 2'b11; s_addr_ok = 1; #1;
        chk("rr1_addr_ok", 32'(m_addr_ok), 32'b01);
        chk("rr1_s_addr", s_addr, 32'h200);
        cyc(); chk("rr2_addr_ok", 32'(m_addr_ok), FX ? 32'b01 : 32'b10);
        chk("rr2_s_addr", s_addr, FX ? 32'h200 : 32'h300);
        cyc(); chk("rr3_addr_ok", 32'(m_addr_ok), 32'b01);
        cyc(); chk("rr4_addr_ok", 32'(m_addr_ok), FX ? 32'b01 : 32'b10);
        cyc(); s_data_ok = 1; #1;
        chk("full_s_req", 32'(s_req), 0);
        chk("full_addr_ok", 32'(m_addr_ok), 0);
        chk("full_pop_data_ok", 32'(m_data_ok), 32'b01);
        cyc(); chk("resume_s_req", 32'(s_req), 1);
        chk("resume_addr_ok", 32'(m_addr_ok), 32'b01);
        chk("resume_data_ok", 32'(m_data_ok), FX ? 32'b01 : 32'b10);
        cyc(); chk("pp_addr_ok", 32'(m_addr_ok), FX ? 32'b01 : 32'b10);
        chk("pp_data_ok", 32'(m_data_ok), 32'b01);
        cyc(); m_req = 0; s_addr_ok = 0; #1;
        chk("drain1", 32'(m_data_ok), FX ? 32'b01 : 32'b10);
        chk("drain_addr_ok", 32'(m_addr_ok), 0);
        cyc(); chk("drain2", 32'(m_data_ok), 32'b01);
        cyc(); chk("drain3", 32'(m_data_ok), FX ? 32'b01 : 32'b10);
        cyc(); s_data_ok = 0;
        // lock: port0 stalled while port1 joins with the rr pointer favouring port1
        m_req = 2'b01; s_addr_ok = 1; #1;
        chk("lk0_addr_ok", 32'(m_addr_ok), 32'b01);
        cyc(); m_addr[31:0] = 32'h240; s_addr_ok = 0; #1;
        chk("lk1_s_req", 32'(s_req), 1);
        chk("lk1_s_addr", s_addr, 32'h240);
        chk("lk1_addr_ok", 32'(m_addr_ok), 0);
        cyc(); m_req = 2'b11; m_write = 2'b10; m_wstrb = 8'hF0; m_wdata[63:32] = 32'hCAFEF00D; #1;
        chk("lk2_s_addr", s_addr, 32'h240);
        chk("lk2_s_write", 32'(s_write), 0);
        cyc(); chk("lk3_s_addr", s_addr, 32'h240);
        chk("lk3_addr_ok", 32'(m_addr_ok), 0);
        cyc(); s_addr_ok = 1; #1;
        chk("lk4_addr_ok", 32'(m_addr_ok), 32'b01);
        chk("lk4_s_addr", s_addr, 32'h240);
        cyc(); chk("lk5_addr_ok", 32'(m_addr_ok), FX ? 32'b01 : 32'b10);
        chk("lk5_s_addr", s_addr, FX ? 32'h240 : 32'h300);
        chk("lk5_s_write", 32'(s_write), FX ? 32'd0 : 32'd1);
        chk("lk5_s_wstrb", 32'(s_wstrb), FX ? 32'h0 : 32'hF);
        chk("lk5_s_wdata", s_wdata, FX ? 32'h0 : 32'hCAFEF00D);
        cyc(); m_req = 0; s_addr_ok = 0; m_write = 0; m_wstrb = 0; s_data_ok = 1; #1;
        chk("lkd1", 32'(m_data_ok), 32'b01);
        cyc(); chk("lkd2", 32'(m_data_ok), 32'b01);
        cyc(); chk("lkd3", 32'(m_data_ok), FX ? 32'b01 : 32'b10);
        // response with empty FIFO
        cyc(); chk("err_data_ok", 32'(m_data_ok), 0);
        chk("err_not_yet", 32'(resp_err), 0);
        cyc(); s_data_ok = 0; #1;
        chk("err_set", 32'(resp_err), 1);
        cyc(); chk("err_sticky", 32'(resp_err), 1);
        // two outstanding, then async reset mid-cycle
        m_req = 2'b01; s_addr_ok = 1;
        cyc(); cyc(); m_req = 2'b11; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h55; #1;
        chk("mb_data_ok", 32'(m_data_ok), 32'b01);
        chk("mb_s_req", 32'(s_req), 1);
        rst_b = 1; #1;
        chk("ar_s_req", 32'(s_req), 0);
        chk("ar_addr_ok", 32'(m_addr_ok), 0);
        chk("ar_data_ok", 32'(m_data_ok), 0);
        chk("ar_resp_err", 32'(resp_err), 0);
        chk("ar_s_addr", s_addr, 0);
        chk("ar_m_rdata", m_rdata, 0);
        cyc(); m_req = 0; s_data_ok = 0; s_rdata = 0; rst_b = 0;
        cyc(); s_data_ok = 1; #1;
        chk("stale_data_ok", 32'(m_data_ok), 0);
        cyc(); s_data_ok = 0; #1;
        chk("stale_err", 32'(resp_err), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
